// File: rtl/vlog_aes_apb_master.sv
// APB initiator for the AES CBC peripheral: loads key/IV/data, triggers, polls status
// and reads back one 128-bit result per accepted command.
module vlog_aes_apb_master #(
    parameter int unsigned vpindex    = 8,
    parameter int unsigned vnapbslv   = 16,
    parameter logic [23:0] vbase      = 24'h0,
    parameter int unsigned POLL_LIMIT = 256
) (
    input  logic                vclk,
    input  logic                vrst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_mode,
    input  logic                cmd_ld_key,
    input  logic                cmd_ld_iv,
    input  logic [127:0]        cmd_key,
    input  logic [127:0]        cmd_iv,
    input  logic [127:0]        cmd_data,
    output logic                rsp_valid,
    output logic [127:0]        rsp_data,
    output logic                rsp_err,
    output logic [vnapbslv-1:0] vpsel,
    output logic                vpenable,
    output logic [31:0]         vpaddr,
    output logic                vpwrite,
    output logic [31:0]         vpwdata,
    input  logic [31:0]         vprdata
);

    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_KEY, S_IV, S_DATA, S_GO_SET, S_GO_CLR,
        S_POLL_LO, S_POLL_HI, S_READ, S_RESP
    } state_t;

    state_t          state, nxt_state;
    logic [1:0]      w, nxt_w;
    logic            mode_q, ld_iv_q, psel_q;
    logic [127:0]    key_q, iv_q, data_q;
    logic [PW-1:0]   poll_cnt;
    logic            start_xfer, timeout, access, stat_bit, poll_last, cur_mode;
    logic [7:0]      bank, xfer_off;
    logic            xfer_wr;
    logic [31:0]     xfer_wdata;
    logic [127:0]    key_src, iv_src, data_src;

    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] k);
        logic [31:0] r;
        case (k)
            2'd0:    r = v[127:96];
            2'd1:    r = v[95:64];
            2'd2:    r = v[63:32];
            default: r = v[31:0];
        endcase
        return r;
    endfunction

    assign access    = psel_q & vpenable;
    assign stat_bit  = mode_q ? vprdata[1] : vprdata[0];
    assign poll_last = (poll_cnt == PW'(POLL_LIMIT - 1));

    // First transfer is decoded from the live command, later ones from the latched copy
    assign cur_mode = (state == S_IDLE) ? cmd_mode : mode_q;
    assign key_src  = (state == S_IDLE) ? cmd_key  : key_q;
    assign iv_src   = (state == S_IDLE) ? cmd_iv   : iv_q;
    assign data_src = (state == S_IDLE) ? cmd_data : data_q;

    // Sequencer: decide the next step at the end of each ACCESS cycle
    always_comb begin
        nxt_state  = state;
        nxt_w      = w;
        start_xfer = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            S_IDLE: if (cmd_valid && cmd_ready) begin
                start_xfer = 1'b1;
                nxt_w      = 2'd0;
                nxt_state  = cmd_ld_key ? S_KEY : (cmd_ld_iv ? S_IV : S_DATA);
            end
            S_KEY: if (access) begin
                start_xfer = 1'b1;
                nxt_w      = w + 2'd1;
                if (w == 2'd3) nxt_state = ld_iv_q ? S_IV : S_DATA;
            end
            S_IV: if (access) begin
                start_xfer = 1'b1;
                nxt_w      = w + 2'd1;
                if (w == 2'd3) nxt_state = S_DATA;
            end
            S_DATA: if (access) begin
                start_xfer = 1'b1;
                nxt_w      = w + 2'd1;
                if (w == 2'd3) nxt_state = S_GO_SET;
            end
            S_GO_SET: if (access) begin
                start_xfer = 1'b1;
                nxt_state  = S_GO_CLR;
            end
            S_GO_CLR: if (access) begin
                start_xfer = 1'b1;
                nxt_state  = S_POLL_LO;
            end
            S_POLL_LO: if (access) begin
                if (!stat_bit) begin
                    start_xfer = 1'b1;
                    nxt_state  = S_POLL_HI;
                end else if (poll_last) begin
                    timeout   = 1'b1;
                    nxt_state = S_RESP;
                end else begin
                    start_xfer = 1'b1;
                end
            end
            S_POLL_HI: if (access) begin
                if (stat_bit) begin
                    start_xfer = 1'b1;
                    nxt_w      = 2'd0;
                    nxt_state  = S_READ;
                end else if (poll_last) begin
                    timeout   = 1'b1;
                    nxt_state = S_RESP;
                end else begin
                    start_xfer = 1'b1;
                end
            end
            S_READ: if (access) begin
                nxt_w = w + 2'd1;
                if (w == 2'd3) nxt_state = S_RESP;
                else           start_xfer = 1'b1;
            end
            S_RESP:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Address/data of the transfer about to be launched
    always_comb begin
        bank       = {3'b000, cur_mode, nxt_w, 2'b00};
        xfer_off   = 8'h00;
        xfer_wr    = 1'b0;
        xfer_wdata = 32'h0;
        case (nxt_state)
            S_KEY:     begin xfer_off = bank;         xfer_wr = 1'b1; xfer_wdata = word_sel(key_src, nxt_w);  end
            S_IV:      begin xfer_off = 8'h40 | bank; xfer_wr = 1'b1; xfer_wdata = word_sel(iv_src, nxt_w);   end
            S_DATA:    begin xfer_off = 8'h20 | bank; xfer_wr = 1'b1; xfer_wdata = word_sel(data_src, nxt_w); end
            S_GO_SET:  begin xfer_off = 8'h80; xfer_wr = 1'b1; xfer_wdata = cur_mode ? 32'd2 : 32'd1; end
            S_GO_CLR:  begin xfer_off = 8'h80; xfer_wr = 1'b1; end
            S_POLL_LO,
            S_POLL_HI: xfer_off = 8'h84;
            S_READ:    xfer_off = 8'h60 | bank;
            default:   xfer_off = 8'h00;
        endcase
    end

    always_comb begin
        vpsel          = '0;
        vpsel[vpindex] = psel_q;
    end

    always_ff @(posedge vclk) begin
        if (!vrst) begin
            state     <= S_IDLE;
            w         <= 2'd0;
            mode_q    <= 1'b0;
            ld_iv_q   <= 1'b0;
            key_q     <= '0;
            iv_q      <= '0;
            data_q    <= '0;
            poll_cnt  <= '0;
            psel_q    <= 1'b0;
            vpenable  <= 1'b0;
            vpaddr    <= 32'h0;
            vpwrite   <= 1'b0;
            vpwdata   <= 32'h0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= nxt_state;
            w         <= nxt_w;
            rsp_valid <= 1'b0;

            if (state == S_IDLE && cmd_valid && cmd_ready) begin
                mode_q    <= cmd_mode;
                ld_iv_q   <= cmd_ld_iv;
                key_q     <= cmd_key;
                iv_q      <= cmd_iv;
                data_q    <= cmd_data;
                cmd_ready <= 1'b0;
                rsp_data  <= '0;
                rsp_err   <= 1'b0;
            end
            if (state == S_RESP) cmd_ready <= 1'b1;

            // Two-cycle transfer: SETUP on launch, ACCESS next, then launch or go idle
            if (start_xfer) begin
                psel_q   <= 1'b1;
                vpenable <= 1'b0;
                vpaddr   <= {vbase, xfer_off};
                vpwrite  <= xfer_wr;
                vpwdata  <= xfer_wdata;
            end else if (psel_q && !vpenable) begin
                vpenable <= 1'b1;
            end else begin
                psel_q   <= 1'b0;
                vpenable <= 1'b0;
            end

            if (nxt_state != state)
                poll_cnt <= '0;
            else if (access && (state == S_POLL_LO || state == S_POLL_HI))
                poll_cnt <= poll_cnt + PW'(1);

            if (state == S_READ && access) begin
                case (w)
                    2'd0:    rsp_data[127:96] <= vprdata;
                    2'd1:    rsp_data[95:64]  <= vprdata;
                    2'd2:    rsp_data[63:32]  <= vprdata;
                    default: rsp_data[31:0]   <= vprdata;
                endcase
            end

            if (nxt_state == S_RESP && state != S_RESP) begin
                rsp_valid <= 1'b1;
                if (timeout) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vlog_aes_apb_master.sv
// Scoreboard bench for vlog_aes_apb_master with a behavioural AES APB slave returning canned results.
module tb_vlog_aes_apb_master;

    localparam int unsigned VPINDEX = 8;
    localparam int unsigned NSLV    = 16;
    localparam int unsigned PL      = 8;
    localparam logic [23:0] VBASE   = 24'h00ABCD;

    localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IV0 = 128'h0;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R3  = 128'hc0ffee00_11223344_a5a5a5a5_5a5a5a5a;
    localparam logic [127:0] R6  = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;

    logic            vclk, vrst;
    logic            cmd_valid, cmd_ready, cmd_mode, cmd_ld_key, cmd_ld_iv;
    logic [127:0]    cmd_key, cmd_iv, cmd_data;
    logic            rsp_valid, rsp_err;
    logic [127:0]    rsp_data;
    logic [NSLV-1:0] vpsel;
    logic            vpenable, vpwrite;
    logic [31:0]     vpaddr, vpwdata, vprdata;

    vlog_aes_apb_master #(.vpindex(VPINDEX), .vnapbslv(NSLV), .vbase(VBASE), .POLL_LIMIT(PL)) dut (
        .vclk(vclk), .vrst(vrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_ld_key(cmd_ld_key), .cmd_ld_iv(cmd_ld_iv),
        .cmd_key(cmd_key), .cmd_iv(cmd_iv), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .vpsel(vpsel), .vpenable(vpenable), .vpaddr(vpaddr), .vpwrite(vpwrite),
        .vpwdata(vpwdata), .vprdata(vprdata)
    );

    initial vclk = 1'b0;
    always #5 vclk = ~vclk;

    typedef struct { logic [7:0] off; logic wr; logic [31:0] data; } txn_t;
    typedef struct { logic [127:0] data; logic err; } rsp_t;

    txn_t   exp_txn[$];
    rsp_t   exp_rsp[$];
    txn_t   mt;
    rsp_t   mr;
    int     checks = 0;
    int     errors = 0;
    int     status_reads = 0;
    bit     txn_en = 1'b1;

    // Slave model state
    logic [127:0] slave_result = '0;
    bit           stuck = 1'b0;
    logic [1:0]   done = 2'b11;
    logic [1:0]   ctrl_q = 2'b00;
    bit           pending = 1'b0;
    int           go_bit = 0;
    int           rd_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wsel(input logic [127:0] v, input int k);
        return v[127 - 32*k -: 32];
    endfunction

    // Status returns the stale done bit once after a go edge, then 0 twice, then 1
    always_comb begin
        vprdata = 32'hdeadbeef;
        if (vpaddr[7:0] == 8'h84)        vprdata = {30'h0, stuck ? 2'b00 : done};
        else if (vpaddr[7:5] == 3'b011)  vprdata = wsel(slave_result, int'(vpaddr[3:2]));
    end

    always @(posedge vclk) begin
        if (vpsel[VPINDEX] && vpenable) begin
            if (vpwrite && vpaddr[7:0] == 8'h80) begin
                ctrl_q <= vpwdata[1:0];
                for (int b = 0; b < 2; b++)
                    if (vpwdata[b] && !ctrl_q[b]) begin
                        pending <= 1'b1;
                        go_bit  <= b;
                        rd_cnt  <= 0;
                    end
            end else if (!vpwrite && vpaddr[7:0] == 8'h84 && pending) begin
                rd_cnt <= rd_cnt + 1;
                if (rd_cnt == 0) done[go_bit] <= 1'b0;
                if (rd_cnt == 2) begin
                    done[go_bit] <= 1'b1;
                    pending      <= 1'b0;
                end
            end
        end
    end

    // Monitor: APB protocol, transaction scoreboard and response scoreboard
    logic        p_sel, p_en, p_wr;
    logic [31:0] p_addr, p_wdata;
    initial begin p_sel = 1'b0; p_en = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0; end

    always @(negedge vclk) begin
        if (vrst && vpenable) begin
            chk("psel_target", 128'(vpsel[VPINDEX]), 128'd1);
            chk("psel_others", 128'(vpsel & ~(NSLV'(1) << VPINDEX)), 128'd0);
            chk("setup_before_access", 128'({p_sel, p_en}), 128'(2'b10));
            chk("stable_addr_wr_data", {63'h0, vpaddr, vpwrite, vpwdata}, {63'h0, p_addr, p_wr, p_wdata});
            chk("addr_base", 128'(vpaddr[31:8]), 128'(VBASE));
            if (!vpwrite && vpaddr[7:0] == 8'h84) begin
                status_reads++;
            end else if (txn_en) begin
                if (exp_txn.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_txn: got off %h wr %b, expected none", vpaddr[7:0], vpwrite);
                end else begin
                    mt = exp_txn.pop_front();
                    chk("txn_off", 128'(vpaddr[7:0]), 128'(mt.off));
                    chk("txn_write", 128'(vpwrite), 128'(mt.wr));
                    if (mt.wr) chk("txn_wdata", 128'(vpwdata), 128'(mt.data));
                end
            end
        end
        if (rsp_valid) begin
            chk("cmd_ready_low_at_rsp", 128'(cmd_ready), 128'd0);
            if (exp_rsp.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_rsp: got data %h err %b, expected no response", rsp_data, rsp_err);
            end else begin
                mr = exp_rsp.pop_front();
                chk("rsp_data", rsp_data, mr.data);
                chk("rsp_err", 128'(rsp_err), 128'(mr.err));
            end
        end
        p_sel   <= vpsel[VPINDEX];
        p_en    <= vpenable;
        p_wr    <= vpwrite;
        p_addr  <= vpaddr;
        p_wdata <= vpwdata;
    end

    task automatic push_words(input logic [7:0] base, input logic wr, input logic [127:0] v);
        for (int k = 0; k < 4; k++) exp_txn.push_back('{base + 8'(4*k), wr, wsel(v, k)});
    endtask

    task automatic expect_block(input logic mode, input logic ld_key, input logic ld_iv,
                                input logic [127:0] key, input logic [127:0] iv, input logic [127:0] data,
                                input logic [127:0] result, input logic err);
        logic [7:0] m8;
        m8 = mode ? 8'h10 : 8'h00;
        if (ld_key) push_words(8'h00 | m8, 1'b1, key);
        if (ld_iv)  push_words(8'h40 | m8, 1'b1, iv);
        push_words(8'h20 | m8, 1'b1, data);
        exp_txn.push_back('{8'h80, 1'b1, mode ? 32'd2 : 32'd1});
        exp_txn.push_back('{8'h80, 1'b1, 32'd0});
        if (!err) push_words(8'h60 | m8, 1'b0, result);
        exp_rsp.push_back('{err ? 128'h0 : result, err});
    endtask

    task automatic send(input logic mode, input logic ld_key, input logic ld_iv,
                        input logic [127:0] key, input logic [127:0] iv, input logic [127:0] data);
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge vclk); n++; end
        if (!cmd_ready) begin checks++; errors++; $display("FAIL cmd_ready_wait: got 0, expected 1"); end
        cmd_valid = 1'b1; cmd_mode = mode; cmd_ld_key = ld_key; cmd_ld_iv = ld_iv;
        cmd_key = key; cmd_iv = iv; cmd_data = data;
        @(negedge vclk);
        // Scramble fields after acceptance; the DUT must have latched them
        cmd_valid = 1'b0; cmd_mode = ~mode; cmd_ld_key = ~ld_key; cmd_ld_iv = ~ld_iv;
        cmd_key = ~key; cmd_iv = ~iv; cmd_data = ~data;
    endtask

    task automatic wait_done(input int exp_status, input logic [127:0] hold_data);
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < 2000) begin @(negedge vclk); n++; end
        if (exp_rsp.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no response, expected %0d", exp_rsp.size());
            exp_rsp.delete();
        end
        repeat (3) @(negedge vclk);
        chk("txn_drain", 128'(exp_txn.size()), 128'd0);
        chk("status_reads", 128'(status_reads), 128'(exp_status));
        chk("rsp_hold", rsp_data, hold_data);
        chk("cmd_ready_after", 128'(cmd_ready), 128'd1);
        exp_txn.delete();
        status_reads = 0;
    endtask

    initial begin
        int n;
        vrst = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_ld_key = 1'b0; cmd_ld_iv = 1'b0;
        cmd_key = '0; cmd_iv = '0; cmd_data = '0;
        repeat (3) @(negedge vclk);
        chk("rst_vpsel", 128'(vpsel), 128'd0);
        chk("rst_vpenable", 128'(vpenable), 128'd0);
        chk("rst_vpaddr", 128'(vpaddr), 128'd0);
        chk("rst_vpwrite", 128'(vpwrite), 128'd0);
        chk("rst_vpwdata", 128'(vpwdata), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_err", 128'(rsp_err), 128'd0);
        chk("rst_rsp_data", rsp_data, 128'd0);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'd1);
        vrst = 1'b1;
        @(negedge vclk);

        // Encrypt FIPS-197 vector with key and IV load
        slave_result = CT;
        expect_block(1'b0, 1'b1, 1'b1, K, IV0, PT, CT, 1'b0);
        send(1'b0, 1'b1, 1'b1, K, IV0, PT);
        wait_done(4, CT);

        // Decrypt back
        slave_result = PT;
        expect_block(1'b1, 1'b1, 1'b1, K, IV0, CT, PT, 1'b0);
        send(1'b1, 1'b1, 1'b1, K, IV0, CT);
        wait_done(4, PT);

        // Chained encrypt, no key/IV reload: first write is to 0x20
        slave_result = R3;
        expect_block(1'b0, 1'b0, 1'b0, K, IV0, PT, R3, 1'b0);
        send(1'b0, 1'b0, 1'b0, K, IV0, PT);
        wait_done(4, R3);

        // Status stuck at 0: POLL_LO passes once, POLL_HI exhausts its budget
        stuck = 1'b1;
        expect_block(1'b0, 1'b0, 1'b0, K, IV0, PT, '0, 1'b1);
        send(1'b0, 1'b0, 1'b0, K, IV0, PT);
        wait_done(PL + 1, 128'h0);
        stuck = 1'b0;

        // Reset during DATA writes
        txn_en = 1'b0;
        send(1'b0, 1'b0, 1'b0, K, IV0, PT);
        n = 0;
        while (!(vpenable && vpaddr[7:0] == 8'h24) && n < 100) begin @(negedge vclk); n++; end
        chk("reached_data_write", 128'(vpenable && vpaddr[7:0] == 8'h24), 128'd1);
        vrst = 1'b0;
        @(negedge vclk);
        chk("midrst_vpsel", 128'(vpsel), 128'd0);
        chk("midrst_vpenable", 128'(vpenable), 128'd0);
        chk("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
        @(negedge vclk);
        vrst = 1'b1;
        @(negedge vclk);
        chk("midrst_cmd_ready", 128'(cmd_ready), 128'd1);
        repeat (60) @(negedge vclk);
        chk("midrst_no_bus", 128'(vpsel), 128'd0);
        txn_en = 1'b1;
        status_reads = 0;

        // Recovery: key reload only, encrypt
        slave_result = R6;
        expect_block(1'b0, 1'b1, 1'b0, K, IV0, CT, R6, 1'b0);
        send(1'b0, 1'b1, 1'b0, K, IV0, CT);
        wait_done(4, R6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
